// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit oversampling, frame-error flag and break handling
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t          state_q;
  logic            rx_meta_q;
  logic            rx_s_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic [7:0]      shift_d;
  logic [7:0]      data_q;
  logic            valid_q;
  logic            err_q;
  logic            busy_q;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign shift_d = {rx_s_q, shift_q[7:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= cnt_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (!rx_s_q) begin
            state_q <= S_START;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            if (!rx_s_q) begin
              state_q <= S_DATA;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q     <= '0;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_q <= S_STOP;
          end
        end
        S_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              err_q   <= 1'b1;
              state_q <= S_WAIT_HIGH;
            end
          end
        end
        S_WAIT_HIGH: begin
          // A held-low line (break) parks here so it reports only one error.
          cnt_q <= '0;
          if (rx_s_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = err_q;
  assign rx_busy    = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed bench for uart_rx at N=16 (main), N=4 and N=100 (sweep)
module tb_uart_rx;

  logic            clk;
  logic            reset;
  logic [2:0]      rxl;
  logic [2:0][7:0] dout;
  logic [2:0]      dv;
  logic [2:0]      fe;
  logic [2:0]      busy;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  int vcnt[3] = '{0, 0, 0};
  int ecnt[3] = '{0, 0, 0};
  int vlast[3] = '{0, 0, 0};
  int elast[3] = '{0, 0, 0};
  int rise[3] = '{0, 0, 0};
  int fall[3] = '{0, 0, 0};
  int both = 0;
  logic [2:0] busy_prev = 3'b000;
  int hist_cyc[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
  logic [7:0] hist_dat[8] = '{8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};

  uart_rx #(.CLKS_PER_BIT(16)) u_dut16 (
    .clk(clk), .reset(reset), .rx(rxl[0]), .data_out(dout[0]),
    .data_valid(dv[0]), .frame_err(fe[0]), .rx_busy(busy[0])
  );
  uart_rx #(.CLKS_PER_BIT(4)) u_dut4 (
    .clk(clk), .reset(reset), .rx(rxl[1]), .data_out(dout[1]),
    .data_valid(dv[1]), .frame_err(fe[1]), .rx_busy(busy[1])
  );
  uart_rx #(.CLKS_PER_BIT(100)) u_dut100 (
    .clk(clk), .reset(reset), .rx(rxl[2]), .data_out(dout[2]),
    .data_valid(dv[2]), .frame_err(fe[2]), .rx_busy(busy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Edge indices recorded here are the posedge that launched the observed level.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (dv[k]) begin
        vcnt[k]  <= vcnt[k] + 1;
        vlast[k] <= cyc;
        if (k == 0) begin
          hist_cyc[vcnt[0] % 8] <= cyc;
          hist_dat[vcnt[0] % 8] <= dout[0];
        end
      end
      if (fe[k]) begin
        ecnt[k]  <= ecnt[k] + 1;
        elast[k] <= cyc;
      end
      if (dv[k] && fe[k]) both <= both + 1;
      if (busy[k] && !busy_prev[k]) rise[k] <= cyc;
      if (!busy[k] && busy_prev[k]) fall[k] <= cyc;
    end
    busy_prev <= busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input int sel, input logic v, input int n);
    rxl[sel] = v;
    idle(n);
  endtask

  task automatic send_frame(input int sel, input logic [7:0] b, input logic stop,
                            input int n, output int start_edge);
    start_edge = cyc + 1;
    drive_bit(sel, 1'b0, n);
    for (int i = 0; i < 8; i++) drive_bit(sel, b[i], n);
    drive_bit(sel, stop, n);
  endtask

  int s, s1, s2, s3, v0, e0, c0;

  initial begin
    reset = 1'b1;
    rxl   = 3'b111;
    idle(3);
    check("reset_data_out", {24'h0, dout[0]}, 32'h00);
    check("reset_valid", {31'h0, dv[0]}, 32'h0);
    check("reset_err", {31'h0, fe[0]}, 32'h0);
    check("reset_busy", {31'h0, busy[0]}, 32'h0);
    reset = 1'b0;
    idle(5);

    // Basic frame 0xA5
    v0 = vcnt[0];
    send_frame(0, 8'hA5, 1'b1, 16, s);
    idle(20);
    check("basic_count", vcnt[0] - v0, 1);
    check("basic_data", {24'h0, dout[0]}, 32'hA5);
    check("basic_valid_edge", vlast[0], s + 154);
    check("basic_no_err", ecnt[0], 0);
    check("basic_busy_rise", rise[0], s + 2);
    check("basic_busy_fall", fall[0], s + 154);

    // Back-to-back 0x00, 0xFF, 0x55
    v0 = vcnt[0];
    send_frame(0, 8'h00, 1'b1, 16, s1);
    send_frame(0, 8'hFF, 1'b1, 16, s2);
    send_frame(0, 8'h55, 1'b1, 16, s3);
    idle(20);
    check("b2b_count", vcnt[0] - v0, 3);
    check("b2b_data0", {24'h0, hist_dat[v0 % 8]}, 32'h00);
    check("b2b_data1", {24'h0, hist_dat[(v0 + 1) % 8]}, 32'hFF);
    check("b2b_data2", {24'h0, hist_dat[(v0 + 2) % 8]}, 32'h55);
    check("b2b_edge0", hist_cyc[v0 % 8], s1 + 154);
    check("b2b_gap01", hist_cyc[(v0 + 1) % 8] - hist_cyc[v0 % 8], 160);
    check("b2b_gap12", hist_cyc[(v0 + 2) % 8] - hist_cyc[(v0 + 1) % 8], 160);

    // Glitch: 3 low cycles
    v0 = vcnt[0];
    e0 = ecnt[0];
    s = cyc + 1;
    rxl[0] = 1'b0;
    idle(3);
    rxl[0] = 1'b1;
    idle(30);
    check("glitch_rise", rise[0], s + 2);
    check("glitch_fall", fall[0], s + 10);
    check("glitch_no_valid", vcnt[0] - v0, 0);
    check("glitch_no_err", ecnt[0] - e0, 0);
    check("glitch_data_held", {24'h0, dout[0]}, 32'h55);

    // Framing error followed by a break, then a good frame
    v0 = vcnt[0];
    e0 = ecnt[0];
    send_frame(0, 8'h3C, 1'b0, 16, s);
    idle(40);
    check("ferr_count", ecnt[0] - e0, 1);
    check("ferr_edge", elast[0], s + 154);
    check("ferr_no_valid", vcnt[0] - v0, 0);
    check("ferr_data_held", {24'h0, dout[0]}, 32'h55);
    check("ferr_busy_in_break", {31'h0, busy[0]}, 32'h1);
    c0 = cyc;
    rxl[0] = 1'b1;
    idle(10);
    check("ferr_busy_fall", fall[0], c0 + 3);
    send_frame(0, 8'h3C, 1'b1, 16, s);
    idle(20);
    check("ferr_recover_data", {24'h0, dout[0]}, 32'h3C);
    check("ferr_recover_count", vcnt[0] - v0, 1);
    check("ferr_single_err", ecnt[0] - e0, 1);

    // Reset during data bit 4 of 0x81
    v0 = vcnt[0];
    e0 = ecnt[0];
    drive_bit(0, 1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(0, i == 0, 16);
    drive_bit(0, 1'b0, 8);
    reset = 1'b1;
    idle(1);
    check("rst_mid_data_out", {24'h0, dout[0]}, 32'h00);
    check("rst_mid_valid", {31'h0, dv[0]}, 32'h0);
    check("rst_mid_err", {31'h0, fe[0]}, 32'h0);
    check("rst_mid_busy", {31'h0, busy[0]}, 32'h0);
    reset = 1'b0;
    rxl[0] = 1'b1;
    idle(200);
    check("rst_mid_no_strobe", (vcnt[0] - v0) + (ecnt[0] - e0), 0);
    send_frame(0, 8'h81, 1'b1, 16, s);
    idle(20);
    check("rst_after_data", {24'h0, dout[0]}, 32'h81);
    check("rst_after_edge", vlast[0], s + 154);

    // Parameter sweep
    send_frame(1, 8'hA5, 1'b1, 4, s);
    idle(20);
    check("n4_data", {24'h0, dout[1]}, 32'hA5);
    check("n4_valid_edge", vlast[1], s + 40);
    check("n4_count", vcnt[1], 1);
    send_frame(2, 8'hA5, 1'b1, 100, s);
    idle(120);
    check("n100_data", {24'h0, dout[2]}, 32'hA5);
    check("n100_valid_edge", vlast[2], s + 952);
    check("n100_count", vcnt[2], 1);

    check("valid_err_exclusive", both, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive half of the UART link. Recovers 8N1 frames (one start bit, 8 data bits LSB first, one stop bit) from the asynchronous `rx` line by oversampling with the system clock. Each good byte is presented on `data_out` with a one-cycle `data_valid` strobe, and malformed frames are flagged on `frame_err`. It sits beside the UART transmit block and feeds received bytes to the system side.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Must be even and ≥ 4.
- `clk` input 1: system clock; all logic is on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `rx` input 1: asynchronous serial line; idle level is 1.
- `data_out` output 8: last correctly received byte; holds until the next good frame.
- `data_valid` output 1: one-cycle pulse when `data_out` is updated.
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled as 0.
- `rx_busy` output 1: high whenever the FSM is not in IDLE.

## Operation
- **Synchronizer:** `rx` passes through a 2-flop synchronizer to give `rx_s`. Both flops reset to 1.
- **Constants:** N = `CLKS_PER_BIT`, H = N/2. Bit counter is 3 bits; cycle counter is $clog2(N) bits.
- **States:** IDLE, START, DATA, STOP, WAIT_HIGH. The cycle counter is cleared to 0 on every state entry and on every sample point.
- **IDLE:**
  - If `rx_s`==0, go to START.
  - Otherwise stay.
- **START:** when cnt==H-1, sample `rx_s` (mid start bit).
  - If 0, go to DATA with bit index 0.
  - If 1, treat as a glitch: go to IDLE, no strobe.
- **DATA:** when cnt==N-1, sample `rx_s` and shift it into the shift register MSB, shifting right, so bit 0 ends at LSB.
  - After bit index 7 is sampled, go to STOP.
- **STOP:** when cnt==N-1, sample `rx_s`.
  - If 1: `data_out` <= shift register, pulse `data_valid`, go to IDLE.
  - If 0: pulse `frame_err`, leave `data_out` unchanged, go to WAIT_HIGH.
- **WAIT_HIGH:** stay until `rx_s`==1, then go to IDLE. A break condition (line held low) therefore yields exactly one `frame_err` and no spurious frames.
- **Output cycle rules:**
  - `data_valid` and `frame_err` are registered and never high in the same cycle.
  - `rx_busy` = (state != IDLE), registered with the state.
- **Reset values:** `data_out`=0x00, `data_valid`=0, `frame_err`=0, `rx_busy`=0, state IDLE, counters 0, shift register 0.
- **Reset mid-frame:** the frame is abandoned; no strobe is produced. Reception restarts on the next start bit after reset deasserts.

## Timing
- Cycle numbering: posedge 0 is the first edge at which the `rx` pin is low.
- `rx_s` is first low after posedge 1. IDLE→START occurs at posedge 2.
- Start-bit sample: posedge 2+H.
- Data bit i sample: posedge 2+H+(i+1)·N, for i = 0..7.
- Stop-bit sample: posedge 2+H+9·N. `data_valid` or `frame_err` is high during the following cycle only.
  - Example, N=16: start sample at posedge 10, bit0 at 26, stop at 154.
- Back-to-back frames: FSM is in IDLE one cycle after the stop sample. A start bit beginning right after the stop bit is detected with no lost cycles.
- Tolerated baud mismatch is set by mid-bit sampling (about ±4% for N=16). Mismatch beyond that surfaces as `frame_err` or corrupt data; it is not detected separately.
- Throughput: one byte per 10·N cycles maximum. There is no backpressure. A consumer that misses the `data_valid` pulse loses the byte; `data_out` still holds it until overwritten.

## Test plan
- **Basic frame:** reset, then drive 0xA5 at N=16 (start, 1,0,1,0,0,1,0,1, stop) → `data_valid` pulses once, after posedge 154; `data_out`=0xA5; `frame_err` stays 0; `rx_busy` high from posedge 2 until the stop sample.
- **Back-to-back:** send 0x00, 0xFF, 0x55 with no idle gap → exactly three `data_valid` pulses, 10·N cycles apart, with the matching values.
- **Glitch:** pull `rx` low for 3 cycles then high → FSM returns to IDLE at posedge 2+H; no `data_valid` or `frame_err`; `data_out` unchanged.
- **Framing error:** send 0x3C with the stop bit driven 0, then hold `rx` low for 40 cycles → one `frame_err` pulse; `data_out` keeps its previous value; `rx_busy` stays high until `rx` returns high, then the next frame 0x3C is received correctly.
- **Reset mid-frame:** assert `reset` for 1 cycle during data bit 4 of 0x81 → all outputs return to reset values the next cycle; no strobe; a following 0x81 frame is received correctly.
- **Parameter sweep:** repeat the basic frame with `CLKS_PER_BIT`=4 and 100 → correct byte; `data_valid` appears after posedge 2+H+9·N for each setting.
